// File: rtl/tx_gearbox.sv
// ---------------------------------------------------------------------------
// tx_gearbox
//
// 64b/66b transmit gearbox. The source delivers each 66-bit block as two
// 32-bit half-blocks, with the sync header on the first half. The gearbox
// repacks the resulting 66-bit stream into 32-bit words for the transceiver.
// Bit 0 of every word goes on the line first.
//
// A frame is 16 blocks, which is 32 half-block transfers and 1056 bits. That
// fills exactly 33 output words, so after transfer 31 there is one pause
// cycle. In that cycle the source is held off and the 32 leftover bits are
// sent.
//
// Ports
//   i_clk            : clock, rising edge
//   i_reset_n        : synchronous active-low reset
//   i_tx_data        : half-block payload (first half = block[31:0])
//   i_tx_sync_hdr    : sync header, only looked at on first halves
//   i_tx_data_valid  : source has a half-block available
//   o_tx_ready       : a half-block can be accepted this cycle
//   o_tx_data        : serial word to the transceiver
//   o_tx_data_valid  : o_tx_data holds a new word
//   o_hdr_err        : pulse for a 2'b00 / 2'b11 header on an accepted first half
// ---------------------------------------------------------------------------
module tx_gearbox #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
    input  logic                  i_tx_data_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_data_valid,
    output logic                  o_hdr_err
);

    localparam int          SEQ_W     = 6;
    localparam int          CW        = 2 * DATA_WIDTH;  // widest combined vector
    localparam logic [SEQ_W-1:0] SEQ_PAUSE = 6'd32;

    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [DATA_WIDTH-1:0] residual_q, residual_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  hdr_err_q, hdr_err_d;

    logic                  pause;
    logic                  xfer;
    logic                  first_half;
    logic [SEQ_W-1:0]      fill;
    logic [CW-1:0]         incoming;
    logic [CW-1:0]         combined;

    always_comb begin
        pause      = (seq_q == SEQ_PAUSE);
        xfer       = i_tx_data_valid && !pause;
        first_half = !seq_q[0];

        // The residual fill is not stored. It follows from seq as
        // 2*ceil(seq/2): an even seq gives seq bits, an odd seq gives seq+1.
        fill = first_half ? seq_q : seq_q + 6'd1;

        // First halves carry the header in the low bits.
        if (first_half)
            incoming = {{(CW-DATA_WIDTH-HDR_WIDTH){1'b0}}, i_tx_data, i_tx_sync_hdr};
        else
            incoming = {{(CW-DATA_WIDTH){1'b0}}, i_tx_data};

        // Residual bits above the fill are always zero, so an OR is enough to
        // merge them. The largest fill + incoming width is 64, so nothing is
        // lost off the top.
        combined = (incoming << fill) | {{(CW-DATA_WIDTH){1'b0}}, residual_q};

        seq_d      = seq_q;
        residual_d = residual_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        hdr_err_d  = 1'b0;

        if (pause) begin
            // The residual holds exactly 32 bits here. Send it and start a
            // new frame with an empty residual.
            data_d     = residual_q;
            residual_d = '0;
            seq_d      = '0;
            valid_d    = 1'b1;
        end else if (xfer) begin
            data_d     = combined[DATA_WIDTH-1:0];
            residual_d = combined[CW-1:DATA_WIDTH];
            seq_d      = seq_q + 6'd1;
            valid_d    = 1'b1;
            // 2'b00 and 2'b11 are the invalid headers: both bits are equal.
            hdr_err_d  = first_half && (i_tx_sync_hdr[0] == i_tx_sync_hdr[1]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            seq_q      <= '0;
            residual_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            hdr_err_q  <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            residual_q <= residual_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            hdr_err_q  <= hdr_err_d;
        end
    end

    assign o_tx_ready      = !pause;
    assign o_tx_data       = data_q;
    assign o_tx_data_valid = valid_q;
    assign o_hdr_err       = hdr_err_q;

endmodule

// File: tb/tb_tx_gearbox.sv
// ---------------------------------------------------------------------------
// tb_tx_gearbox
//
// Directed-vector bench for tx_gearbox. There is a table of single-cycle
// vectors with hand-computed results. Hand-written sequences cover a full
// frame, an underflow stall, valid held through the pause cycle, and reset
// in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_tx_gearbox;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_hdr;
    logic        in_valid;
    logic        ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        hdr_err;

    int tests;
    int fails;

    tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_tx_data       (in_data),
        .i_tx_sync_hdr   (in_hdr),
        .i_tx_data_valid (in_valid),
        .o_tx_ready      (ready),
        .o_tx_data       (out_data),
        .o_tx_data_valid (out_valid),
        .o_hdr_err       (hdr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [1:0]  hdr;
        logic [31:0] data;
        logic        exp_ready;   // all expectations are sampled after the edge
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_hdr   = 2'b01;
        tick();
        rst_n    = 1'b1;
    endtask

    // One frame of 16 random blocks. With do_stall set, valid drops for 5
    // cycles when the bench's own transfer count reaches 9. At the pause
    // cycle, valid stays high with the next frame's first half. That half
    // must then be accepted as seq 0.
    task automatic run_frame(input bit do_stall);
        logic [31:0] d [32];
        logic [1:0]  h [16];
        logic [31:0] nd;
        logic [1:0]  nh;
        bit          expq[$];
        bit          outq[$];
        int          t;
        int          stall_left;
        int          words;
        int          mism;
        bit          paused;
        bit          stall_now;
        logic [31:0] last;

        do_reset();
        for (int i = 0; i < 32; i++) d[i] = $urandom;
        for (int i = 0; i < 16; i++) h[i] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        nd = $urandom;
        nh = 2'b10;
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 2; k++)  expq.push_back(h[b][k]);
            for (int k = 0; k < 32; k++) expq.push_back(d[2*b][k]);
            for (int k = 0; k < 32; k++) expq.push_back(d[2*b+1][k]);
        end

        t          = 0;
        stall_left = do_stall ? 5 : 0;
        words      = 0;
        paused     = 1'b0;
        last       = out_data;
        for (int c = 0; c < 80 && !paused; c++) begin
            stall_now = (t == 9) && (stall_left > 0);
            in_valid  = !stall_now;
            in_data   = (t < 32) ? d[t] : nd;
            in_hdr    = (t < 32) ? h[t/2] : nh;
            #1;
            chk(do_stall ? "stall_ready" : "frame_ready", {31'd0, ready}, {31'd0, (t != 32)});
            tick();
            chk(do_stall ? "stall_valid" : "frame_valid", {31'd0, out_valid}, {31'd0, !stall_now});
            if (out_valid) begin
                words++;
                last = out_data;
                for (int k = 0; k < 32; k++) outq.push_back(out_data[k]);
            end else begin
                chk("stall_hold", out_data, last);
            end
            if (t == 32)       paused = 1'b1;
            else if (stall_now) stall_left--;
            else               t++;
        end
        chk("frame_done", {31'd0, paused}, 32'd1);
        chk("frame_words", words, 33);
        chk("frame_bits", outq.size(), expq.size());
        mism = 0;
        for (int k = 0; k < expq.size() && k < outq.size(); k++)
            if (outq[k] != expq[k]) mism++;
        chk("frame_stream", mism, 0);

        // Same data, still valid: now accepted as the first half of a new
        // frame with an empty residual.
        #1;
        chk("pause_ready", {31'd0, ready}, 32'd1);
        tick();
        chk("pause_next_valid", {31'd0, out_valid}, 32'd1);
        chk("pause_next_data", out_data, {nd[29:0], nh});
        in_valid = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_hdr   = 2'b01;

        // Each row is the inputs for one edge, followed by the outputs
        // expected after that edge.
        vecs[0] = '{1'b0, 1'b0, 2'b01, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        // seq0: {AAAAAAAA,01} -> low 32 = AAAAAAA9, residual = 2'b10
        vecs[1] = '{1'b1, 1'b1, 2'b01, 32'hAAAA_AAAA, 1'b1, 1'b1, 32'hAAAA_AAA9, 1'b0};
        // seq1: (12345678<<2)|2'b10
        vecs[2] = '{1'b1, 1'b1, 2'b11, 32'h1234_5678, 1'b1, 1'b1, 32'h48D1_59E2, 1'b0};
        // stall: output held, no valid
        vecs[3] = '{1'b1, 1'b0, 2'b01, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h48D1_59E2, 1'b0};
        // seq2, bad header 11: 34 ones << 2, residual gets 4'hF
        vecs[4] = '{1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1};
        // seq3, header 11 on a second half: no error
        vecs[5] = '{1'b1, 1'b1, 2'b11, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_000F, 1'b0};
        // seq4, bad header 00: {1,00} << 4
        vecs[6] = '{1'b1, 1'b1, 2'b00, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0040, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 2'b01, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0040, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst_n    = vecs[i].rst_n;
            in_valid = vecs[i].valid;
            in_hdr   = vecs[i].hdr;
            in_data  = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_ready", i), {31'd0, ready},     {31'd0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i),  out_data,           vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i),   {31'd0, hdr_err},   {31'd0, vecs[i].exp_err});
        end
        in_valid = 1'b0;
        tick();
        chk("err_one_cycle", {31'd0, hdr_err}, 32'd0);

        run_frame(1'b0);
        run_frame(1'b1);

        // Reset in the middle of a frame, at seq 17.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_hdr   = 2'b01;
            in_data  = $urandom;
            tick();
        end
        rst_n   = 1'b0;
        in_data = 32'hCAFE_F00D;
        tick();
        chk("midrst_data",  out_data,           32'h0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, ready},     32'd1);
        chk("midrst_err",   {31'd0, hdr_err},   32'd0);
        rst_n   = 1'b1;
        in_hdr  = 2'b10;
        in_data = 32'h1111_1111;
        tick();
        chk("midrst_first_valid", {31'd0, out_valid}, 32'd1);
        chk("midrst_first_data",  out_data,           32'h4444_4446);
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
